// File: rtl/sdram_loader_pkg.sv
// rtl/sdram_loader_pkg.sv - shared constants and state encoding for the SDRAM loader
package sdram_loader_pkg;

    localparam int ADDR_W  = 25;
    localparam int WADDR_W = 24;
    localparam int DATA_W  = 16;

    localparam logic [15:0] CYCLES_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/sdram_loader.sv
// rtl/sdram_loader.sv - packs a byte stream into 16-bit SDRAM word writes
module sdram_loader
    import sdram_loader_pkg::*;
#(
    parameter int CYCLES_PER_WORD = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  length,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               sdram_req,
    output logic [WADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0]  sdram_data,
    output logic [1:0]         sdram_be,
    input  logic               sdram_ack,
    output logic               loader_busy,
    output logic [15:0]        loader_cycles_left,
    output logic               done
);

    state_e             state_q, state_d;
    logic [WADDR_W-1:0] base_q, base_d;
    logic [WADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0]  accept_left_q, accept_left_d;
    logic [ADDR_W-1:0]  bytes_left_q, bytes_left_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [1:0]         be_q, be_d;
    logic               hi_lane_q, hi_lane_d;
    logic [15:0]        cycles_q, cycles_d;
    logic [ADDR_W-1:0]  word_bytes;

    // Words still to write times the per-word cost, clamped to the 16-bit output.
    function automatic logic [15:0] cycles_est(input logic [ADDR_W-1:0] bytes);
        logic [31:0] words;
        logic [31:0] est;
        words = ({7'd0, bytes} + 32'd1) >> 1;
        est   = words * 32'(CYCLES_PER_WORD);
        return (est > {16'd0, CYCLES_SAT}) ? CYCLES_SAT : est[15:0];
    endfunction

    assign in_ready           = (state_q == ST_COLLECT) && (accept_left_q != '0);
    assign sdram_req          = (state_q == ST_WRITE);
    assign loader_busy        = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign done               = (state_q == ST_DONE);
    assign sdram_addr         = base_q + idx_q;
    assign sdram_data         = data_q;
    assign sdram_be           = be_q;
    assign loader_cycles_left = cycles_q;
    assign word_bytes         = be_q[1] ? ADDR_W'(2) : ADDR_W'(1);

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        idx_d         = idx_q;
        accept_left_d = accept_left_q;
        bytes_left_d  = bytes_left_q;
        data_d        = data_q;
        be_d          = be_q;
        hi_lane_d     = hi_lane_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        base_d        = WADDR_W'(base_addr >> 1);
                        idx_d         = '0;
                        accept_left_d = length;
                        bytes_left_d  = length;
                        data_d        = '0;
                        hi_lane_d     = 1'b0;
                        state_d       = ST_COLLECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_COLLECT: begin
                if (in_valid && in_ready) begin
                    accept_left_d = accept_left_q - 1'b1;
                    if (hi_lane_q) begin
                        data_d[15:8] = in_data;
                        be_d         = 2'b11;
                        hi_lane_d    = 1'b0;
                        state_d      = ST_WRITE;
                    end else begin
                        data_d = {8'h00, in_data};
                        // Last byte of an odd length goes out alone in the low lane.
                        if (accept_left_q == ADDR_W'(1)) begin
                            be_d    = 2'b01;
                            state_d = ST_WRITE;
                        end else begin
                            hi_lane_d = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (sdram_ack) begin
                    idx_d        = idx_q + 1'b1;
                    bytes_left_d = (bytes_left_q > word_bytes) ? bytes_left_q - word_bytes : '0;
                    state_d      = (bytes_left_d == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Estimate tracks the registered state, so it lags state/count changes by one clock.
    always_comb begin
        cycles_d = '0;
        if (loader_busy) begin
            cycles_d = cycles_est(bytes_left_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            idx_q         <= '0;
            accept_left_q <= '0;
            bytes_left_q  <= '0;
            data_q        <= '0;
            be_q          <= '0;
            hi_lane_q     <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            idx_q         <= idx_d;
            accept_left_q <= accept_left_d;
            bytes_left_q  <= bytes_left_d;
            data_q        <= data_d;
            be_q          <= be_d;
            hi_lane_q     <= hi_lane_d;
            cycles_q      <= cycles_d;
        end
    end

endmodule
